// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction fetch bridge: FSM encoding,
// bus size code, kseg base addresses and the virtual-to-physical map.
package inst_fetch_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DISCARD = 3'd4
  } fetch_state_e;

  localparam logic [1:0]  SIZE_WORD  = 2'b10;
  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space,
  // so translation is just clearing the top three address bits.
  function automatic logic [31:0] map_vaddr(input logic [31:0] vaddr,
                                            input logic        kseg_map);
    logic [31:0] paddr;
    paddr = vaddr;
    if (kseg_map && ((vaddr[31:29] == KSEG0_BASE[31:29]) ||
                     (vaddr[31:29] == KSEG1_BASE[31:29]))) begin
      paddr = {3'b000, vaddr[28:0]};
    end
    return paddr;
  endfunction

endpackage

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: converts the IF-stage PC into SRAM-like bus
// transactions, stalls the pipeline while a fetch is outstanding, buffers
// the returned word across pipeline stalls and drops responses made stale
// by a flush.
//
// Bus handshake: a request is transferred on a cycle where inst_req and
// inst_addr_ok are both high; once inst_req is raised, inst_addr stays
// constant until that transfer. Read data is transferred on any cycle with
// inst_data_ok high; at most one request is outstanding, so every
// inst_data_ok belongs to the single accepted request.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter bit          KSEG_MAP    = 1'b1,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  if_pc,
  input  logic         if_en,
  input  logic         if_flush,
  input  logic         pipe_stall,
  output logic [31:0]  if_instr,
  output logic         stallreq_from_if,
  output logic         inst_req,
  output logic         inst_wr,
  output logic [1:0]   inst_size,
  output logic [31:0]  inst_addr,
  output logic [31:0]  inst_wdata,
  input  logic         inst_addr_ok,
  input  logic         inst_data_ok,
  input  logic [31:0]  inst_rdata,
  output fetch_state_e dbg_state
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_buf;

  logic         w_start;
  logic         w_req;
  logic         w_stall;
  logic [31:0]  w_addr;
  logic [31:0]  w_instr;

  // A fetch may start only for an aligned PC that is wanted and not flushed.
  assign w_start = if_en && (if_pc[1:0] == 2'b00) && !if_flush;

  // Fetch FSM: tracks the single outstanding transaction and the held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_buf   <= RESET_INSTR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_pc    <= if_pc;
            r_state <= inst_addr_ok ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          if (if_flush) begin
            r_state <= inst_addr_ok ? ST_DISCARD : ST_IDLE;
          end else if (inst_addr_ok) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (if_flush) begin
            // Data arriving with the flush completes the stale transaction.
            r_state <= inst_data_ok ? ST_IDLE : ST_DISCARD;
          end else if (inst_data_ok) begin
            if (pipe_stall) begin
              r_buf   <= inst_rdata;
              r_state <= ST_HOLD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (if_flush) begin
            r_buf   <= RESET_INSTR;
            r_state <= ST_IDLE;
          end else if (!pipe_stall) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (inst_data_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus request, stall request and instruction mux for the current state.
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_addr  = map_vaddr(r_pc, KSEG_MAP);
    w_instr = RESET_INSTR;
    case (r_state)
      ST_IDLE: begin
        w_req   = w_start;
        w_stall = w_start;
        w_addr  = map_vaddr(if_pc, KSEG_MAP);
      end
      ST_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
      end
      ST_WAIT: begin
        if (inst_data_ok) begin
          if (!if_flush) begin
            w_instr = inst_rdata;
          end
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_HOLD: begin
        w_instr = r_buf;
      end
      default: begin
        w_req   = 1'b0;
      end
    endcase
  end

  // Reset also masks the combinational IDLE path so nothing escapes while low.
  assign inst_req         = rst && w_req;
  assign stallreq_from_if = rst && w_stall;
  assign if_instr         = rst ? w_instr : RESET_INSTR;
  assign inst_addr        = w_addr;
  assign inst_wr          = 1'b0;
  assign inst_size        = SIZE_WORD;
  assign inst_wdata       = 32'h0000_0000;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
module tb_inst_fetch_bridge;
  import inst_fetch_bridge_pkg::*;

  localparam logic [31:0] RESET_INSTR = 32'h0000_0000;
  localparam bit          KSEG_MAP    = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  if_pc;
  logic         if_en, if_flush, pipe_stall;
  logic         addr_ok, data_ok;
  logic [31:0]  rdata;
  logic [31:0]  if_instr, inst_addr, inst_wdata;
  logic         stallreq, inst_req, inst_wr;
  logic [1:0]   inst_size;
  fetch_state_e dbg_state;

  inst_fetch_bridge #(.KSEG_MAP(KSEG_MAP), .RESET_INSTR(RESET_INSTR)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_en(if_en), .if_flush(if_flush),
    .pipe_stall(pipe_stall), .if_instr(if_instr), .stallreq_from_if(stallreq),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(addr_ok),
    .inst_data_ok(data_ok), .inst_rdata(rdata), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  int n_hs     = 0;
  logic [31:0] exp_q[$];   // words the pipeline must receive, in order

  // Reference model: a pending request, an in-flight read, a held word.
  bit          m_want, m_inflight, m_stale, m_held;
  logic [31:0] m_pc, m_word;

  // Auto slave for the random phase.
  bit auto_slave = 1'b0;
  bit s_busy     = 1'b0;
  int s_delay    = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // kseg0 and kseg1 both alias physical 0..512MB.
  function automatic logic [31:0] phys(input logic [31:0] va);
    if (KSEG_MAP && va >= 32'h8000_0000 && va < 32'hC000_0000)
      return va - ((va >= 32'hA000_0000) ? 32'hA000_0000 : 32'h8000_0000);
    return va;
  endfunction

  task automatic model_clear();
    m_want = 0; m_inflight = 0; m_stale = 0; m_held = 0;
    m_pc = '0; m_word = RESET_INSTR;
    s_busy = 0; s_delay = 0;
  endtask

  // One compare per meaningful cycle, then advance the model by one edge.
  task automatic model_step();
    logic [31:0] e_instr, e_addr;
    logic        e_req, e_stall, start;
    if (!rst) begin
      check32("rst_req", {31'b0, inst_req}, 32'd0);
      check32("rst_stall", {31'b0, stallreq}, 32'd0);
      check32("rst_instr", if_instr, RESET_INSTR);
      model_clear();
      return;
    end
    e_instr = RESET_INSTR; e_addr = '0; e_req = 0; e_stall = 0;
    start = if_en && (if_pc[1:0] == 2'b00) && !if_flush;
    if (m_held) begin
      e_instr = m_word;
    end else if (m_inflight) begin
      if (data_ok) begin
        if (!m_stale && !if_flush) e_instr = rdata;
      end else begin
        e_stall = !m_stale;
      end
    end else if (m_want) begin
      e_req = 1; e_stall = 1; e_addr = phys(m_pc);
    end else begin
      e_req = start; e_stall = start; e_addr = phys(if_pc);
    end
    check32("m_req", {31'b0, inst_req}, {31'b0, e_req});
    check32("m_stall", {31'b0, stallreq}, {31'b0, e_stall});
    check32("m_instr", if_instr, e_instr);
    if (e_req) check32("m_addr", inst_addr, e_addr);
    check32("m_const", {inst_wr, inst_size, inst_wdata[28:0]}, {1'b0, 2'b10, 29'd0});
    if (e_instr != RESET_INSTR && !m_held) exp_q.push_back(e_instr);
    if (inst_req && addr_ok) n_hs++;
    // advance model
    if (m_held) begin
      if (if_flush || !pipe_stall) m_held = 0;
    end else if (m_inflight) begin
      if (data_ok) begin
        m_inflight = 0;
        if (!m_stale && !if_flush && pipe_stall) begin m_held = 1; m_word = rdata; end
      end else if (if_flush) begin
        m_stale = 1;
      end
    end else if (m_want) begin
      if (addr_ok) begin m_want = 0; m_inflight = 1; m_stale = if_flush; end
      else if (if_flush) m_want = 0;
    end else if (start) begin
      if (addr_ok) begin m_inflight = 1; m_stale = 0; end
      else begin m_want = 1; m_pc = if_pc; end
    end
    // advance slave
    if (auto_slave) begin
      if (inst_req && addr_ok) begin s_busy = 1; s_delay = $urandom_range(0, 3); end
      else if (s_busy && data_ok) s_busy = 0;
      else if (s_busy && s_delay > 0) s_delay--;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic fl,
                       input logic ps, input logic aok, input logic dok,
                       input logic [31:0] rd);
    if_en = en; if_pc = pc; if_flush = fl; pipe_stall = ps;
    addr_ok = aok; data_ok = dok; rdata = rd;
    #1;
  endtask

  logic [31:0] w;
  int hs0;

  initial begin
    rst = 0;
    model_clear();
    drive(1, 32'hBFC0_0000, 0, 0, 0, 0, 0);
    // reset values, with a fetch wanted on the inputs
    check32("reset_req", {31'b0, inst_req}, 32'd0);
    check32("reset_stall", {31'b0, stallreq}, 32'd0);
    check32("reset_instr", if_instr, 32'h0);
    check32("reset_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    tick(); tick();
    rst = 1;
    drive(0, 32'h0, 0, 0, 0, 0, 0);

    // back-to-back fetch, addr_ok in request cycle, data_ok next
    drive(1, 32'hBFC0_0000, 0, 0, 1, 0, 0);
    check32("b2b_req0", {31'b0, inst_req}, 32'd1);
    check32("b2b_addr0", inst_addr, 32'h1FC0_0000);
    check32("b2b_stall0", {31'b0, stallreq}, 32'd1);
    tick();
    drive(1, 32'hBFC0_0000, 0, 0, 0, 1, 32'h3C08_0001);
    check32("b2b_instr0", if_instr, 32'h3C08_0001);
    check32("b2b_nostall0", {31'b0, stallreq}, 32'd0);
    tick();
    drive(1, 32'hBFC0_0004, 0, 0, 1, 0, 0);
    check32("b2b_addr1", inst_addr, 32'h1FC0_0004);
    check32("b2b_req1", {31'b0, inst_req}, 32'd1);
    tick();
    drive(1, 32'hBFC0_0004, 0, 0, 0, 1, 32'h2409_0002);
    check32("b2b_instr1", if_instr, 32'h2409_0002);
    tick();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    tick();

    // delayed addr_ok: request and address held for three cycles
    hs0 = n_hs;
    drive(1, 32'hBFC0_0010, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check32("dly_req", {31'b0, inst_req}, 32'd1);
      check32("dly_addr", inst_addr, 32'h1FC0_0010);
      tick();
      drive(1, 32'hBFC0_0020, 0, 0, 0, 0, 0);
    end
    drive(0, 32'hBFC0_0020, 0, 0, 1, 0, 0);
    check32("dly_addr_hs", inst_addr, 32'h1FC0_0010);
    tick();
    drive(0, 32'h0, 0, 0, 0, 1, 32'h1111_2222);
    check32("dly_instr", if_instr, 32'h1111_2222);
    tick();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    tick();
    check32("dly_handshakes", n_hs - hs0, 32'd1);

    // pipe_stall at data_ok: word held across stalled cycles
    drive(1, 32'hBFC0_0030, 0, 0, 1, 0, 0);
    tick();
    drive(1, 32'hBFC0_0030, 0, 1, 0, 1, 32'h2408_0001);
    check32("hold_bypass", if_instr, 32'h2408_0001);
    check32("hold_nostall", {31'b0, stallreq}, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'hBFC0_0030, 0, 1, 1, 0, 0);
      check32("hold_instr", if_instr, 32'h2408_0001);
      check32("hold_noreq", {31'b0, inst_req}, 32'd0);
      check32("hold_state", {29'b0, dbg_state}, {29'b0, ST_HOLD});
      tick();
    end
    drive(1, 32'hBFC0_0034, 0, 0, 1, 0, 0);
    check32("hold_last", if_instr, 32'h2408_0001);
    check32("hold_last_noreq", {31'b0, inst_req}, 32'd0);
    tick();
    check32("hold_next_req", {31'b0, inst_req}, 32'd1);
    tick();
    drive(0, 32'h0, 0, 0, 0, 1, 32'h0000_0021);
    tick();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    tick();

    // flush in WAIT, stale data arrives two cycles later
    drive(1, 32'hBFC0_0040, 0, 0, 1, 0, 0);
    tick();
    drive(1, 32'hBFC0_0380, 1, 0, 0, 0, 0);
    tick();
    drive(1, 32'hBFC0_0380, 0, 0, 0, 0, 0);
    check32("dis_noreq", {31'b0, inst_req}, 32'd0);
    check32("dis_nostall", {31'b0, stallreq}, 32'd0);
    tick();
    drive(1, 32'hBFC0_0380, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check32("dis_instr", if_instr, 32'h0);
    check32("dis_noreq2", {31'b0, inst_req}, 32'd0);
    tick();
    drive(1, 32'hBFC0_0380, 0, 0, 1, 0, 0);
    check32("dis_next_req", {31'b0, inst_req}, 32'd1);
    check32("dis_next_addr", inst_addr, 32'h1FC0_0380);
    tick();
    drive(0, 32'h0, 0, 0, 0, 1, 32'h4200_0018);
    tick();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    tick();

    // misaligned PC
    drive(1, 32'hBFC0_0002, 0, 0, 1, 0, 0);
    check32("mis_req", {31'b0, inst_req}, 32'd0);
    check32("mis_instr", if_instr, 32'h0);
    check32("mis_stall", {31'b0, stallreq}, 32'd0);
    tick(); tick();

    // reset asserted in WAIT
    drive(1, 32'hBFC0_0050, 0, 0, 1, 0, 0);
    tick();
    drive(1, 32'hBFC0_0050, 0, 0, 0, 0, 0);
    check32("rw_stall_pre", {31'b0, stallreq}, 32'd1);
    rst = 0;
    #1;
    check32("rw_req", {31'b0, inst_req}, 32'd0);
    check32("rw_stall", {31'b0, stallreq}, 32'd0);
    check32("rw_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    tick();
    rst = 1;
    drive(0, 32'h0, 0, 0, 0, 1, 32'hCAFE_F00D);
    check32("rw_late_instr", if_instr, 32'h0);
    check32("rw_late_stall", {31'b0, stallreq}, 32'd0);
    tick();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    tick();

    // randomized traffic against the model
    auto_slave = 1;
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 4))
        0: w = 32'hBFC0_0000;
        1: w = 32'h8000_1000;
        2: w = 32'h0040_0000;
        3: w = 32'hA000_2000;
        default: w = 32'hC000_0000;
      endcase
      w = w + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) w[1:0] = 2'($urandom_range(1, 3));
      if_pc      = w;
      if_en      = ($urandom_range(0, 5) != 0);
      if_flush   = ($urandom_range(0, 9) == 0);
      pipe_stall = ($urandom_range(0, 2) == 0);
      data_ok    = s_busy && (s_delay == 0);
      addr_ok    = !s_busy && ($urandom_range(0, 2) != 0);
      rdata      = $urandom;
      #1;
      tick();
    end
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
